qeciphy_crc8_framer: RTL and testbench
======================================

QECIPHY_CRC8_FRAMER -- requirements
Module: qeciphy_crc8_framer

Interface
REQ-001 The block SHALL have parameter FRAME_BYTES, default 7, giving the payload bytes per frame; legal range is 1..255.
REQ-002 The block SHALL have port clk_i, input, 1 bit: the single clock; all logic is synchronous to its rising edge.
REQ-003 The block SHALL have port rst_i, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port s_tdata_i, input, 8 bits: payload byte from the upstream source.
REQ-005 The block SHALL have port s_tvalid_i, input, 1 bit: the upstream byte is valid.
REQ-006 The block SHALL have port s_tready_o, output, 1 bit: the block accepts the upstream byte this cycle.
REQ-007 The block SHALL have port m_tdata_o, output, 8 bits: downstream byte, either a payload byte or the CRC byte.
REQ-008 The block SHALL have port m_tvalid_o, output, 1 bit: the downstream byte is valid.
REQ-009 The block SHALL have port m_tlast_o, output, 1 bit: the downstream byte is the CRC byte that ends the frame.
REQ-010 The block SHALL have port m_tready_i, input, 1 bit: the downstream sink accepts the byte.
REQ-011 The block SHALL have port frame_cnt_o, output, 16 bits: count of completed frames, wrapping modulo 2^16.

Function
REQ-012 The block SHALL compute CRC-8/SMBUS over each frame's payload: polynomial 0x07, init 0x00, MSB-first, no reflection, no final XOR, one byte per cycle.
REQ-013 The block SHALL implement a two-state FSM with states DATA and CRC, entering DATA at reset.
REQ-014 The output register SHALL be free (out_free) when m_tvalid_o=0 or m_tready_i=1.
REQ-015 s_tready_o SHALL be combinational and equal (state==DATA) AND out_free; it SHALL NOT depend on s_tvalid_i.
REQ-016 In DATA, a byte SHALL be accepted when s_tvalid_i and s_tready_o are both high; on acceptance the block SHALL set m_tdata_o to the byte, m_tvalid_o to 1 and m_tlast_o to 0 on the next edge, giving one cycle of latency.
REQ-017 On each acceptance the block SHALL update the CRC accumulator with the accepted byte and increment the 8-bit byte counter.
REQ-018 On acceptance of the byte at count FRAME_BYTES-1, the block SHALL clear the byte counter and move to CRC.
REQ-019 In CRC with out_free, the block SHALL load m_tdata_o with the final CRC and set m_tvalid_o and m_tlast_o to 1 on the next edge.
REQ-020 On that same CRC-byte load edge, the block SHALL clear the accumulator to 0x00, increment frame_cnt_o and return to DATA.
REQ-021 In CRC, s_tready_o SHALL be 0, so each frame costs exactly one input stall cycle.
REQ-022 When m_tready_i=1 and no new byte is loaded that cycle, m_tvalid_o SHALL go to 0 on the next edge and m_tlast_o SHALL go to 0.
REQ-023 While m_tvalid_o=1 and m_tready_i=0, m_tdata_o and m_tlast_o SHALL hold stable, and the accumulator, counters and state SHALL hold.
REQ-024 The block SHALL never drop or duplicate a byte; with m_tready_i held at 1 it SHALL sustain one output beat per cycle.
REQ-025 frame_cnt_o SHALL wrap from 0xFFFF to 0x0000 without any flag.
REQ-026 With FRAME_BYTES=1, every payload byte SHALL be followed directly by its CRC byte.

Reset
REQ-027 When rst_i=1 at a clock edge, the block SHALL set m_tvalid_o=0, m_tlast_o=0, m_tdata_o=0x00, frame_cnt_o=0, accumulator=0x00, byte counter=0 and state=DATA.
REQ-028 While rst_i=1, s_tready_o SHALL be 0.
REQ-029 Reset asserted mid-frame or mid-CRC SHALL discard the partial frame, emit no CRC byte, and start the next accepted byte as byte 0 of a new frame.

Verification
REQ-030 FRAME_BYTES=9, input ASCII "123456789" (0x31..0x39), m_tready_i=1 -> 10 output beats, the 10th being 0xF4 with m_tlast_o=1, and frame_cnt_o=1.
REQ-031 FRAME_BYTES=1, input 0x01 then 0xFF -> outputs 0x01, 0x07(last), 0xFF, 0xF3(last); frame_cnt_o=2.
REQ-032 FRAME_BYTES=7, seven 0x00 bytes -> CRC byte 0x00 with last; then a second frame of "1234567" -> CRC matching the software model, confirming the accumulator restarts from 0x00.
REQ-033 Continuous s_tvalid_i=1 and m_tready_i=1 over 3 frames of FRAME_BYTES=7 -> 24 output beats in 24 cycles, s_tready_o low exactly once per frame.
REQ-034 m_tready_i=0 for 5 cycles mid-payload and again during the CRC byte -> output held stable, s_tready_o=0, and no loss or duplication against the model.
REQ-035 rst_i pulsed after 3 of 7 bytes, then a full frame of 7 bytes sent -> no tlast before the reset, and the post-reset CRC equals the CRC of those 7 bytes alone.

Source files
------------

// File: rtl/qeciphy_crc8_framer.sv
// qeciphy_crc8_framer: appends a CRC-8/SMBUS byte after every FRAME_BYTES payload bytes on a byte stream
module qeciphy_crc8_framer #(
  parameter int FRAME_BYTES = 7
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [7:0]  s_tdata_i,
  input  logic        s_tvalid_i,
  output logic        s_tready_o,
  output logic [7:0]  m_tdata_o,
  output logic        m_tvalid_o,
  output logic        m_tlast_o,
  input  logic        m_tready_i,
  output logic [15:0] frame_cnt_o
);
  typedef enum logic {DATA, CRC} state_t;
  localparam logic [7:0] LAST_IDX = 8'(FRAME_BYTES - 1);
  state_t state, state_nxt;
  logic [7:0] acc, cnt, crc_nxt;
  logic out_free, accept, last_byte;
  function automatic logic [7:0] crc8_byte(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] r;
    r = c ^ d;
    for (int k = 0; k < 8; k++) r = r[7] ? ({r[6:0], 1'b0} ^ 8'h07) : {r[6:0], 1'b0};
    return r;
  endfunction
  always_comb begin
    out_free   = !m_tvalid_o || m_tready_i;
    s_tready_o = !rst_i && state == DATA && out_free;
    accept     = s_tvalid_i && s_tready_o;
    last_byte  = cnt == LAST_IDX;
    crc_nxt    = crc8_byte(acc, s_tdata_i);
    state_nxt  = (accept && last_byte) ? CRC : (state == CRC && out_free) ? DATA : state;
  end
  always_ff @(posedge clk_i) state <= rst_i ? DATA : state_nxt;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      m_tdata_o   <= 8'h00;
      m_tvalid_o  <= 1'b0;
      m_tlast_o   <= 1'b0;
      acc         <= 8'h00;
      cnt         <= 8'h00;
      frame_cnt_o <= 16'h0000;
    end else if (accept) begin
      m_tdata_o  <= s_tdata_i;
      m_tvalid_o <= 1'b1;
      m_tlast_o  <= 1'b0;
      acc        <= crc_nxt;
      cnt        <= last_byte ? 8'h00 : cnt + 8'h01;
    end else if (state == CRC && out_free) begin
      m_tdata_o   <= acc;
      m_tvalid_o  <= 1'b1;
      m_tlast_o   <= 1'b1;
      acc         <= 8'h00;
      frame_cnt_o <= frame_cnt_o + 16'h0001;
    end else if (m_tready_i) begin
      m_tvalid_o <= 1'b0;
      m_tlast_o  <= 1'b0;
    end
  end
endmodule

// File: tb/tb_qeciphy_crc8_framer.sv
// tb_qeciphy_crc8_framer: directed vector bench for qeciphy_crc8_framer at FRAME_BYTES 9, 1 and 7
module tb_qeciphy_crc8_framer;
  localparam int FB [3] = '{9, 1, 7};
  typedef struct packed {
    logic [1:0]      inst;
    logic [3:0]      n;
    logic [8:0][7:0] d;
    logic [7:0]      crc;
    logic            model;
  } vec_t;
  logic clk = 1'b0;
  logic rst;
  logic [2:0][7:0]  s_tdata, m_tdata;
  logic [2:0]       s_tvalid, s_tready, m_tvalid, m_tlast, m_tready;
  logic [2:0][15:0] fcnt;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 3; g++) begin : g_dut
    qeciphy_crc8_framer #(.FRAME_BYTES(FB[g])) u_dut (
      .clk_i(clk), .rst_i(rst),
      .s_tdata_i(s_tdata[g]), .s_tvalid_i(s_tvalid[g]), .s_tready_o(s_tready[g]),
      .m_tdata_o(m_tdata[g]), .m_tvalid_o(m_tvalid[g]), .m_tlast_o(m_tlast[g]),
      .m_tready_i(m_tready[g]), .frame_cnt_o(fcnt[g])
    );
  end
  logic [7:0] src_q[$], sent_q[$];
  logic [8:0] out_q[$];
  logic [255:0] stall;
  vec_t vt [5];
  int total, bad, nready_low, first_beat, last_beat, held_last;
  int exp_fc [3];
  function automatic logic [7:0] crc_model(input logic [7:0] c, input logic [7:0] b);
    logic [7:0] r;
    logic fb;
    r = c;
    for (int k = 7; k >= 0; k--) begin
      fb = r[7] ^ b[k];
      r = {r[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    end
    return r;
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask
  task automatic send(input logic [7:0] b);
    src_q.push_back(b);
    sent_q.push_back(b);
  endtask
  task automatic run(input int i, input int cycles);
    logic pv, pr, pl;
    logic [7:0] pd;
    pv = 1'b0; pr = 1'b1; pl = 1'b0; pd = 8'h00;
    nready_low = 0; first_beat = -1; last_beat = -1; held_last = 0;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      s_tvalid[i] = src_q.size() > 0;
      s_tdata[i]  = src_q.size() > 0 ? src_q[0] : 8'h00;
      m_tready[i] = !stall[c];
      #1;
      if (pv && !pr) begin
        chk("hold_valid", 32'(m_tvalid[i]), 1);
        chk("hold_data", 32'(m_tdata[i]), 32'(pd));
        chk("hold_last", 32'(m_tlast[i]), 32'(pl));
      end
      if (m_tvalid[i] && !m_tready[i]) begin
        chk("stall_sready", 32'(s_tready[i]), 0);
        held_last += int'(m_tlast[i]);
      end
      if (!s_tready[i]) nready_low++;
      if (s_tvalid[i] && s_tready[i]) void'(src_q.pop_front());
      if (m_tvalid[i] && m_tready[i]) begin
        out_q.push_back({m_tlast[i], m_tdata[i]});
        if (first_beat < 0) first_beat = c;
        last_beat = c;
      end
      pv = m_tvalid[i]; pr = m_tready[i]; pd = m_tdata[i]; pl = m_tlast[i];
    end
    s_tvalid[i] = 1'b0;
  endtask
  task automatic check_out(input int i, input string tag);
    logic [8:0] exp_q[$];
    logic [7:0] c;
    int k;
    c = 8'h00; k = 0;
    foreach (sent_q[j]) begin
      exp_q.push_back({1'b0, sent_q[j]});
      c = crc_model(c, sent_q[j]);
      k++;
      if (k == FB[i]) begin
        exp_q.push_back({1'b1, c});
        c = 8'h00; k = 0;
      end
    end
    chk({tag, "_beats"}, out_q.size(), exp_q.size());
    foreach (exp_q[j])
      if (j < out_q.size()) chk($sformatf("%s_beat%0d", tag, j), 32'(out_q[j]), 32'(exp_q[j]));
    sent_q.delete();
    out_q.delete();
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; s_tvalid = '0; m_tready = '1;
    repeat (2) @(negedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst_sready%0d", i), 32'(s_tready[i]), 0);
      chk($sformatf("rst_valid%0d", i), 32'(m_tvalid[i]), 0);
      chk($sformatf("rst_last%0d", i), 32'(m_tlast[i]), 0);
      chk($sformatf("rst_data%0d", i), 32'(m_tdata[i]), 0);
      chk($sformatf("rst_fcnt%0d", i), 32'(fcnt[i]), 0);
      exp_fc[i] = 0;
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_sready", 32'(s_tready[2]), 1);
  endtask
  initial begin
    vec_t r;
    logic [7:0] e;
    rst = 1'b1; s_tvalid = '0; s_tdata = '0; m_tready = '1; stall = '0;
    total = 0; bad = 0;
    vt[0] = '{inst: 2'd0, n: 4'd9, d: 72'h393837363534333231, crc: 8'hF4, model: 1'b0};
    vt[1] = '{inst: 2'd1, n: 4'd1, d: 72'h01, crc: 8'h07, model: 1'b0};
    vt[2] = '{inst: 2'd1, n: 4'd1, d: 72'hFF, crc: 8'hF3, model: 1'b0};
    vt[3] = '{inst: 2'd2, n: 4'd7, d: 72'h00, crc: 8'h00, model: 1'b0};
    vt[4] = '{inst: 2'd2, n: 4'd7, d: 72'h37363534333231, crc: 8'h00, model: 1'b1};
    do_reset();
    for (int v = 0; v < 5; v++) begin
      r = vt[v];
      e = 8'h00;
      for (int k = 0; k < int'(r.n); k++) begin
        src_q.push_back(r.d[k]);
        e = crc_model(e, r.d[k]);
      end
      if (!r.model) e = r.crc;
      out_q.delete();
      run(int'(r.inst), int'(r.n) + 3);
      chk($sformatf("v%0d_beats", v), out_q.size(), 32'(r.n) + 1);
      for (int k = 0; k < int'(r.n); k++)
        if (k < out_q.size()) chk($sformatf("v%0d_byte%0d", v, k), 32'(out_q[k]), {23'd0, 1'b0, r.d[k]});
      if (out_q.size() > int'(r.n)) chk($sformatf("v%0d_crc", v), 32'(out_q[r.n]), {23'd0, 1'b1, e});
      exp_fc[r.inst]++;
      chk($sformatf("v%0d_fcnt", v), 32'(fcnt[r.inst]), 32'(exp_fc[r.inst]));
    end
    out_q.delete();
    for (int k = 0; k < 21; k++) send(8'(k * 5 + 3));
    run(2, 26);
    chk("tput_beats", out_q.size(), 24);
    chk("tput_span", last_beat - first_beat, 23);
    chk("tput_stalls", nready_low, 3);
    check_out(2, "tput");
    exp_fc[2] += 3;
    chk("tput_fcnt", 32'(fcnt[2]), 32'(exp_fc[2]));
    stall = '0;
    for (int c = 3; c <= 7; c++) stall[c] = 1'b1;
    for (int c = 13; c <= 16; c++) stall[c] = 1'b1;
    for (int k = 0; k < 7; k++) send(8'hA0 + 8'(k));
    run(2, 22);
    stall = '0;
    chk("stall_crc_held", held_last, 4);
    check_out(2, "stall");
    exp_fc[2]++;
    chk("stall_fcnt", 32'(fcnt[2]), 32'(exp_fc[2]));
    for (int k = 0; k < 3; k++) send(8'h5A ^ 8'(k));
    run(2, 4);
    chk("pre_rst_beats", out_q.size(), 3);
    e = 8'h00;
    foreach (out_q[j]) e += 8'(out_q[j][8]);
    chk("pre_rst_last", 32'(e), 0);
    sent_q.delete();
    out_q.delete();
    do_reset();
    for (int k = 0; k < 7; k++) send(8'hC3 + 8'(k * 17));
    run(2, 10);
    check_out(2, "post_rst");
    chk("post_rst_fcnt", 32'(fcnt[2]), 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
